// File: rtl/hamming_serial_decoder.sv
// -----------------------------------------------------------------------------
// hamming_serial_decoder
// Serial Hamming(7,4) decoder and single-error corrector. It assembles a
// 7-bit codeword from strobed serial bits, computes the syndrome, corrects any
// single-bit error and re-serialises the 4 corrected data bits with its own
// strobe. It also keeps a saturating count of frames that had a non-zero
// syndrome.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   strobe_in   d_in carries a valid codeword bit this cycle
//   d_in        serial codeword bit, c0 first, c6 last
//   strobe_out  high for exactly 4 consecutive cycles per decoded frame
//   d_out       corrected data bit, d0 first; 0 when strobe_out is low
//   err_flag    syndrome of the last frame was non-zero (held)
//   err_pos     last syndrome {s2,s1,s0} (held)
//   err_cnt     frames with non-zero syndrome, saturating at 255
//
// Codeword layout c[6:0] = {p2,p1,p0,d3,d2,d1,d0}.
// -----------------------------------------------------------------------------
module hamming_serial_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe_in,
    input  logic       d_in,
    output logic       strobe_out,
    output logic       d_out,
    output logic       err_flag,
    output logic [2:0] err_pos,
    output logic [7:0] err_cnt
);

    localparam int unsigned CW_W     = 7;
    localparam int unsigned DATA_W   = 4;
    localparam int unsigned SYN_W    = 3;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned RX_CNT_W = 3;
    localparam int unsigned TX_IDX_W = 2;

    localparam logic [RX_CNT_W-1:0] RX_LAST  = RX_CNT_W'(CW_W - 1);
    localparam logic [TX_IDX_W-1:0] TX_LAST  = TX_IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_TX   = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------
    logic [RX_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [CW_W-1:0]     rx_sr_q,  rx_sr_d;
    logic                frame_ready_q, frame_ready_d;

    // Shift in from the top so that after 7 strobes rx_sr_q[i] holds c_i.
    always_comb begin
        rx_cnt_d      = rx_cnt_q;
        rx_sr_d       = rx_sr_q;
        frame_ready_d = 1'b0;
        if (strobe_in) begin
            rx_sr_d = {d_in, rx_sr_q[CW_W-1:1]};
            if (rx_cnt_q == RX_LAST) begin
                rx_cnt_d      = '0;
                frame_ready_d = 1'b1;
            end else begin
                rx_cnt_d = rx_cnt_q + RX_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_q      <= '0;
            rx_sr_q       <= '0;
            frame_ready_q <= 1'b0;
        end else begin
            rx_cnt_q      <= rx_cnt_d;
            rx_sr_q       <= rx_sr_d;
            frame_ready_q <= frame_ready_d;
        end
    end

    // ------------------------------------------------------------------
    // Syndrome and correction
    // ------------------------------------------------------------------
    // rx_sr_q is only consumed on the cycle frame_ready_q is high; the next
    // frame's c0 shifts in on that same edge, so the word is still intact.
    logic [SYN_W-1:0]  syndrome;
    logic [DATA_W-1:0] flip_mask;
    logic [DATA_W-1:0] data_corr;

    always_comb begin
        syndrome[0] = rx_sr_q[4] ^ rx_sr_q[0] ^ rx_sr_q[1] ^ rx_sr_q[3];
        syndrome[1] = rx_sr_q[5] ^ rx_sr_q[0] ^ rx_sr_q[2] ^ rx_sr_q[3];
        syndrome[2] = rx_sr_q[6] ^ rx_sr_q[1] ^ rx_sr_q[2] ^ rx_sr_q[3];
    end

    // Single-bit syndromes point at parity bits: data passes unchanged.
    always_comb begin
        flip_mask = '0;
        unique case (syndrome)
            3'b011:  flip_mask = 4'b0001;
            3'b101:  flip_mask = 4'b0010;
            3'b110:  flip_mask = 4'b0100;
            3'b111:  flip_mask = 4'b1000;
            default: flip_mask = '0;
        endcase
    end

    assign data_corr = rx_sr_q[DATA_W-1:0] ^ flip_mask;

    // ------------------------------------------------------------------
    // Decode / transmit FSM
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [TX_IDX_W-1:0] tx_idx_q, tx_idx_d;
    logic [TX_IDX_W-1:0] tx_idx_nxt;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                strobe_out_q, strobe_out_d;
    logic                d_out_q, d_out_d;
    logic                err_flag_q, err_flag_d;
    logic [SYN_W-1:0]    err_pos_q, err_pos_d;
    logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

    assign tx_idx_nxt = tx_idx_q + TX_IDX_W'(1);

    // A new frame always wins: it restarts TX at index 0 even mid-burst.
    always_comb begin
        state_d      = state_q;
        tx_idx_d     = tx_idx_q;
        tx_d         = tx_q;
        strobe_out_d = 1'b0;
        d_out_d      = 1'b0;
        err_flag_d   = err_flag_q;
        err_pos_d    = err_pos_q;
        err_cnt_d    = err_cnt_q;

        if (frame_ready_q) begin
            state_d      = ST_TX;
            tx_d         = data_corr;
            tx_idx_d     = '0;
            strobe_out_d = 1'b1;
            d_out_d      = data_corr[0];
            err_flag_d   = |syndrome;
            err_pos_d    = syndrome;
            if ((|syndrome) && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_TX: begin
                    if (tx_idx_q == TX_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_idx_d     = tx_idx_nxt;
                        strobe_out_d = 1'b1;
                        d_out_d      = tx_q[tx_idx_nxt];
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tx_idx_q     <= '0;
            tx_q         <= '0;
            strobe_out_q <= 1'b0;
            d_out_q      <= 1'b0;
            err_flag_q   <= 1'b0;
            err_pos_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            tx_idx_q     <= tx_idx_d;
            tx_q         <= tx_d;
            strobe_out_q <= strobe_out_d;
            d_out_q      <= d_out_d;
            err_flag_q   <= err_flag_d;
            err_pos_q    <= err_pos_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign strobe_out = strobe_out_q;
    assign d_out      = d_out_q;
    assign err_flag   = err_flag_q;
    assign err_pos    = err_pos_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// -----------------------------------------------------------------------------
// tb_hamming_serial_decoder
// Self-checking bench: encodes random nibbles, injects at most one bit error,
// streams frames into the decoder and compares each 4-bit output burst and the
// error status against an expected-frame queue.
// -----------------------------------------------------------------------------
module tb_hamming_serial_decoder;

    logic       clk;
    logic       rst;
    logic       strobe_in;
    logic       d_in;
    logic       strobe_out;
    logic       d_out;
    logic       err_flag;
    logic [2:0] err_pos;
    logic [7:0] err_cnt;

    hamming_serial_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .strobe_in  (strobe_in),
        .d_in       (d_in),
        .strobe_out (strobe_out),
        .d_out      (d_out),
        .err_flag   (err_flag),
        .err_pos    (err_pos),
        .err_cnt    (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] nib;
        logic [2:0] pos;
        logic [7:0] cnt;
        int         start;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec     = 0;
    int   n_err     = 0;
    int   model_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Syndrome the code produces for an error at codeword position p (7 = none).
    function automatic logic [2:0] syn_of(input int p);
        case (p)
            0: return 3'b011;
            1: return 3'b101;
            2: return 3'b110;
            3: return 3'b111;
            4: return 3'b001;
            5: return 3'b010;
            6: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Encode nib, flip bit 'flip' (7 = none), optionally pause after bit gap_after.
    task automatic send_frame(input logic [3:0] nib, input int flip,
                              input int gap_after, input int gap_len);
        logic [6:0] c;
        exp_t       e;
        c = {nib[1] ^ nib[2] ^ nib[3], nib[0] ^ nib[2] ^ nib[3],
             nib[0] ^ nib[1] ^ nib[3], nib};
        if (flip < 7) c = c ^ (7'd1 << flip);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            strobe_in = 1'b1;
            d_in      = c[i];
            if (i == 6) begin
                if (flip < 7 && model_cnt < 255) model_cnt++;
                e.nib   = nib;
                e.pos   = syn_of(flip);
                e.cnt   = 8'(model_cnt);
                e.start = cyc + 2;
                exp_q.push_back(e);
            end
            if (i == gap_after) begin
                repeat (gap_len) begin
                    @(negedge clk);
                    strobe_in = 1'b0;
                    d_in      = 1'($urandom);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            strobe_in = 1'b0;
            d_in      = 1'($urandom);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_strobe_out"}, 32'(strobe_out), 32'd0);
        check({tag, "_d_out"},      32'(d_out),      32'd0);
        check({tag, "_err_flag"},   32'(err_flag),   32'd0);
        check({tag, "_err_pos"},    32'(err_pos),    32'd0);
        check({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
    endtask

    // Output monitor: collects each 4-bit burst and checks it against the queue.
    int nbits = 0;
    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
        end else if (strobe_out) begin
            if (exp_q.size() == 0) begin
                check("spurious_strobe", 32'(strobe_out), 32'd0);
            end else begin
                if (nbits == 0) check("latency", 32'(cyc), 32'(exp_q[0].start));
                check("d_out", 32'(d_out), 32'(exp_q[0].nib[nbits]));
                nbits++;
                if (nbits == 4) begin
                    check("err_flag", 32'(err_flag), 32'(exp_q[0].pos != 3'b000));
                    check("err_pos",  32'(err_pos),  32'(exp_q[0].pos));
                    check("err_cnt",  32'(err_cnt),  32'(exp_q[0].cnt));
                    void'(exp_q.pop_front());
                    nbits = 0;
                end
            end
        end else begin
            check("d_out_idle", 32'(d_out), 32'd0);
            if (nbits != 0) begin
                check("burst_len", 32'(strobe_out), 32'd1);
                nbits = 0;
            end
        end
    end

    initial begin
        rst       = 1'b0;
        strobe_in = 1'b0;
        d_in      = 1'b0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_state("por");
        @(negedge clk);
        #2 rst = 1'b0;

        // Directed frames
        send_frame(4'b1011, 7, -1, 0); idle(10);
        send_frame(4'b1011, 1, -1, 0); idle(10);
        send_frame(4'b0000, 3, -1, 0); idle(10);
        send_frame(4'b0000, 4, -1, 0); idle(10);
        send_frame(4'b1011, 7, 3, 3);  idle(10);

        // Random frames with random gaps and error positions
        repeat (40) begin
            send_frame(4'($urandom), int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
            idle(int'($urandom_range(0, 3)));
        end
        idle(10);

        // Back-to-back errored frames, strobe_in held high; drives err_cnt to saturation
        repeat (300) send_frame(4'($urandom), int'($urandom_range(0, 6)), -1, 0);
        idle(10);
        check("sat_cnt", 32'(err_cnt), 32'd255);

        // Reset during the second output bit, with a partial next frame in flight
        send_frame(4'($urandom), 5, -1, 0);
        @(negedge clk); strobe_in = 1'b1; d_in = 1'($urandom);
        @(negedge clk); strobe_in = 1'b1; d_in = 1'($urandom);
        @(negedge clk); strobe_in = 1'b0;
        #2 rst = 1'b1;
        exp_q.delete();
        model_cnt = 0;
        #1 check_reset_state("midtx_rst");
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        idle(2);
        send_frame(4'b1011, 7, -1, 0);
        idle(10);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
